// File: rtl/wb_dma_sequencer.sv
// Descriptor-driven Wishbone DMA sequencer.
// Walks a fixed descriptor table, one bus transaction at a time.
module wb_dma_sequencer #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int CW = 13,
  parameter int NDESC = 4,
  parameter logic [NDESC*AW-1:0] DESC_SRC = '0,
  parameter logic [NDESC*AW-1:0] DESC_DST = '0,
  parameter logic [NDESC*CW-1:0] DESC_LEN = '0,
  parameter logic [NDESC*2-1:0] DESC_MODE = '0,
  parameter logic [NDESC*DW-1:0] DESC_FILL = '0,
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  output logic wb_cyc_o,
  output logic wb_stb_o,
  output logic wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic wb_ack_i,
  input  logic wb_err_i,
  input  logic soft_reset,
  input  logic [NDESC-1:0] desc_en,
  output logic dma_busy,
  output logic dma_done,
  output logic [((NDESC > 1) ? $clog2(NDESC) : 1)-1:0] cur_desc,
  output logic [7:0] err_cnt
);

  localparam int IW = (NDESC > 1) ? $clog2(NDESC) : 1;
  localparam int QW = $clog2(NDESC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] M_FILL = 2'd1;
  localparam logic [1:0] M_TERM = 2'd2;
  localparam logic [1:0] M_FIXSRC = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_NEXT, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic act_q, act_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] prog_q, prog_d;
  logic [QW-1:0] desc_q, desc_d;
  logic [NDESC-1:0] mask_q, mask_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [7:0] err_q, err_d;

  logic in_tab;
  logic [IW-1:0] idx;
  logic [AW-1:0] src, dst;
  logic [CW-1:0] len;
  logic [1:0] mode;
  logic [DW-1:0] fill, wdata;
  logic tmo_hit, b_ok, b_err, b_end;
  logic last_el, stop_el;
  logic [7:0] err_inc;

  assign in_tab = desc_q < QW'(NDESC);
  assign idx = in_tab ? desc_q[IW-1:0] : '0;
  assign src = DESC_SRC[idx*AW +: AW];
  assign dst = DESC_DST[idx*AW +: AW];
  assign len = DESC_LEN[idx*CW +: CW];
  assign mode = DESC_MODE[idx*2 +: 2];
  assign fill = DESC_FILL[idx*DW +: DW];
  assign wdata = (mode == M_FILL) ? fill : buf_q;

  // err wins over ack; timeout only counts if nothing terminated
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  assign b_err = act_q & (wb_err_i | (~wb_ack_i & tmo_hit));
  assign b_ok = act_q & wb_ack_i & ~wb_err_i;
  assign b_end = b_ok | b_err;

  assign last_el = prog_q == len;
  assign stop_el = last_el | ((mode == M_TERM) & wdata[DW-1]);
  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      act_q <= 1'b0;
      tmo_q <= '0;
      prog_q <= '0;
      desc_q <= '0;
      mask_q <= '0;
      buf_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      tmo_q <= tmo_d;
      prog_q <= prog_d;
      desc_q <= desc_d;
      mask_q <= mask_d;
      buf_q <= buf_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d = act_q;
    tmo_d = act_q ? tmo_q + 1'b1 : '0;
    prog_d = prog_q;
    desc_d = desc_q;
    mask_d = mask_q;
    buf_d = buf_q;
    err_d = b_err ? err_inc : err_q;
    unique case (state_q)
      S_IDLE: begin
        mask_d = desc_en;
        desc_d = '0;
        prog_d = '0;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!in_tab) state_d = S_DONE;
        else if (!mask_q[idx]) desc_d = desc_q + 1'b1;
        else state_d = (mode == M_FILL) ? S_WR : S_RD;
      end
      S_RD: begin
        if (!act_q) begin
          act_d = 1'b1;
        end else if (b_ok) begin
          buf_d = wb_dat_i;
          act_d = 1'b0;
          state_d = S_WR;
        end else if (b_err) begin
          act_d = 1'b0;
          if (last_el) begin
            state_d = S_NEXT;
            desc_d = desc_q + 1'b1;
            prog_d = '0;
          end else begin
            prog_d = prog_q + 1'b1;
          end
        end
      end
      S_WR: begin
        if (!act_q) begin
          act_d = 1'b1;
        end else if (b_end) begin
          act_d = 1'b0;
          if (stop_el) begin
            state_d = S_NEXT;
            desc_d = desc_q + 1'b1;
            prog_d = '0;
          end else begin
            prog_d = prog_q + 1'b1;
            state_d = (mode == M_FILL) ? S_WR : S_RD;
          end
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (soft_reset) begin
      state_d = S_IDLE;
      act_d = 1'b0;
      tmo_d = '0;
      prog_d = '0;
      desc_d = '0;
      err_d = '0;
    end
  end

  always_comb begin
    wb_cyc_o = act_q;
    wb_stb_o = act_q;
    wb_we_o = act_q & (state_q == S_WR);
    wb_adr_o = '0;
    wb_dat_o = '0;
    if (act_q) begin
      if (state_q == S_WR) begin
        wb_adr_o = dst + AW'(prog_q);
        wb_dat_o = wdata;
      end else begin
        wb_adr_o = (mode == M_FIXSRC) ? src : src + AW'(prog_q);
      end
    end
    dma_busy = (state_q == S_RD) | (state_q == S_WR) |
               (state_q == S_NEXT);
    dma_done = state_q == S_DONE;
    cur_desc = in_tab ? idx : IW'(NDESC - 1);
    err_cnt = err_q;
  end

endmodule

// File: tb/tb_wb_dma_sequencer.sv
// Scoreboard bench for wb_dma_sequencer: a descriptor-level model
// predicts every bus transaction and the final error count.
module tb_wb_dma_sequencer;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n, soft_reset;
  logic cyc, stb, we, ack, err;
  logic [15:0] adr, dat_o, dat_i;
  logic [3:0] desc_en;
  logic dma_busy, dma_done;
  logic [1:0] cur_desc;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  // descriptor table; modes 0 COPY, 1 FILL, 2 TERM, 3 FIXSRC
  logic [15:0] SRC [4] = '{16'h0000, 16'h0100, 16'h0000, 16'hFFFE};
  logic [15:0] DST [4] = '{16'h0080, 16'h0200, 16'h0300, 16'hFFFE};
  logic [15:0] FILLV [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
  int LEN [4] = '{3, 15, 1, 2};
  int MODE [4] = '{0, 2, 1, 3};

  wb_dma_sequencer #(
    .DW(16), .AW(16), .CW(13), .NDESC(4),
    .DESC_SRC({16'hFFFE, 16'h0000, 16'h0100, 16'h0000}),
    .DESC_DST({16'hFFFE, 16'h0300, 16'h0200, 16'h0080}),
    .DESC_LEN({13'd2, 13'd1, 13'd15, 13'd3}),
    .DESC_MODE({2'd3, 2'd1, 2'd2, 2'd0}),
    .DESC_FILL({16'h0000, 16'hFFFF, 16'h0000, 16'h0000}),
    .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .wb_cyc_o(cyc),
    .wb_stb_o(stb),
    .wb_we_o(we),
    .wb_adr_o(adr),
    .wb_dat_o(dat_o),
    .wb_dat_i(dat_i),
    .wb_ack_i(ack),
    .wb_err_i(err),
    .soft_reset(soft_reset),
    .desc_en(desc_en),
    .dma_busy(dma_busy),
    .dma_done(dma_done),
    .cur_desc(cur_desc),
    .err_cnt(err_cnt)
  );

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent
  typedef struct {
    bit we;
    logic [15:0] adr;
    logic [15:0] dat;
    int desc;
    int kind;
    int dly;
    int ncyc;
  } txn_t;

  txn_t sq[$];
  txn_t mq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;
  bit abort = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk(input int scen, input bit w,
                              input int d, input logic [15:0] a);
    txn_t t;
    int r;
    r = $urandom_range(99);
    t.we = w;
    t.adr = a;
    t.desc = d;
    t.dat = 16'($urandom);
    t.dly = $urandom_range(2);
    t.ncyc = 0;
    t.kind = (r < 80) ? 0 : (r < 88) ? 1 : (r < 94) ? 2 : 3;
    if (scen != 0) begin
      t.kind = 0;
      t.dly = 0;
    end
    if (!w && MODE[d] == 2)
      t.dat[15] = (scen == 0) && ($urandom_range(7) == 0);
    return t;
  endfunction

  task automatic push(input txn_t t);
    t.ncyc = (t.kind == 3) ? TO : t.dly + 1;
    sq.push_back(t);
    mq.push_back(t);
  endtask

  // scen: 0 random, 1 clean, 2 TERM hit on word 2,
  // 3 read 1 silent, 4 read 0 err + write 1 silent
  task automatic build(input logic [3:0] mask, input int scen);
    int errs;
    txn_t t;
    logic [15:0] w;
    errs = 0;
    for (int d = 0; d < 4; d++) begin
      if (!mask[d]) continue;
      for (int p = 0; p <= LEN[d]; p++) begin
        if (MODE[d] != 1) begin
          t = mk(scen, 1'b0, d,
                 (MODE[d] == 3) ? SRC[d] : SRC[d] + 16'(p));
          if (scen == 2 && p == 2) t.dat = 16'h8001;
          if (scen == 3 && p == 1) t.kind = 3;
          if (scen == 4 && p == 0) t.kind = 1;
          push(t);
          if (t.kind != 0) begin
            errs++;
            continue;
          end
          w = t.dat;
        end else begin
          w = FILLV[d];
        end
        t = mk(scen, 1'b1, d, DST[d] + 16'(p));
        t.dat = w;
        if (scen == 4 && p == 1) t.kind = 3;
        push(t);
        if (t.kind != 0) errs++;
        if (MODE[d] == 2 && w[15]) break;
      end
    end
    exp_err = (errs > 255) ? 255 : errs;
  endtask

  // slave: answers each transaction from the planned response queue
  initial begin
    txn_t s;
    bit sact;
    int cnt;
    sact = 1'b0;
    cnt = 0;
    ack = 1'b0;
    err = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk);
      if (cyc && stb) begin
        if (!sact) begin
          sact = 1'b1;
          if (sq.size() != 0) begin
            s = sq.pop_front();
          end else begin
            s.kind = 3;
            s.dly = 0;
            s.dat = '0;
          end
          cnt = s.dly;
        end
        if (cnt > 0) begin
          cnt--;
        end else if (s.kind != 3) begin
          ack = (s.kind == 0) || (s.kind == 2);
          err = (s.kind != 0);
          dat_i = s.dat;
        end
      end else begin
        sact = 1'b0;
        ack = 1'b0;
        err = 1'b0;
      end
    end
  end

  // monitor: pops the expected transaction at each cyc rise
  initial begin
    txn_t c;
    bit have, prev, stab;
    int held;
    logic [15:0] a0, d0;
    logic w0;
    have = 1'b0;
    prev = 1'b0;
    stab = 1'b1;
    held = 0;
    forever begin
      @(negedge clk);
      if (cyc && !prev) begin
        chk("txn_expected", 32'(mq.size() != 0), 1);
        have = mq.size() != 0;
        if (have) begin
          c = mq.pop_front();
          chk("adr", adr, c.adr);
          chk("we", we, c.we);
          if (c.we) chk("wdat", dat_o, c.dat);
          chk("cur_desc", cur_desc, c.desc);
          chk("stb", stb, 1);
        end
        a0 = adr;
        d0 = dat_o;
        w0 = we;
        held = 0;
        stab = 1'b1;
      end
      if (cyc) begin
        held++;
        if (adr !== a0 || dat_o !== d0 || we !== w0 || stb !== 1'b1)
          stab = 1'b0;
      end
      if (!cyc && prev && have && !abort) begin
        chk("hold_cycles", held, c.ncyc);
        chk("hold_stable", stab, 1);
      end
      if (!cyc && prev) have = 1'b0;
      prev = cyc;
    end
  end

  task automatic chk_idle(input string nm);
    chk({nm, "_ctl"}, {cyc, stb, we, dma_busy, dma_done}, 0);
    chk({nm, "_adr"}, adr, 0);
    chk({nm, "_dat"}, dat_o, 0);
    chk({nm, "_cur"}, cur_desc, 0);
    chk({nm, "_err"}, err_cnt, 0);
  endtask

  task automatic run_to_done(input string nm);
    int n;
    n = 0;
    while (!dma_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, dma_done, 1);
    chk({nm, "_err_cnt"}, err_cnt, exp_err);
    chk({nm, "_drained"}, mq.size(), 0);
    chk({nm, "_busy"}, dma_busy, 0);
  endtask

  task automatic start_run(input logic [3:0] mask, input int scen);
    @(negedge clk);
    soft_reset = 1'b1;
    desc_en = mask;
    @(negedge clk);
    sq.delete();
    mq.delete();
    build(mask, scen);
    abort = 1'b0;
    soft_reset = 1'b0;
  endtask

  initial begin
    int n, lat;
    rst_n = 1'b0;
    soft_reset = 1'b0;
    desc_en = 4'b0001;
    repeat (3) @(negedge clk);
    chk_idle("reset");

    build(4'b0001, 1);
    rst_n = 1'b1;
    run_to_done("copy");

    start_run(4'b0010, 2);
    run_to_done("term");

    start_run(4'b0100, 1);
    run_to_done("fill");

    start_run(4'b0001, 3);
    run_to_done("timeout");

    start_run(4'b0000, 1);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (dma_done && lat == 0) lat = i;
    end
    chk("alloff_latency", lat, 6);
    chk("alloff_err", err_cnt, 0);

    start_run(4'b0001, 4);
    n = 0;
    while (!(cyc && we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sr_wr_seen", cyc && we, 1);
    abort = 1'b1;
    soft_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("sr_cyc", {cyc, stb}, 0);
    chk("sr_err", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    sq.delete();
    mq.delete();
    desc_en = 4'b0001;
    build(4'b0001, 0);
    abort = 1'b0;
    soft_reset = 1'b0;
    run_to_done("restart");

    start_run(4'b1111, 1);
    n = 0;
    while (!(cyc && !we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("arst_rd_seen", cyc && !we, 1);
    #2;
    abort = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    @(negedge clk);
    @(negedge clk);
    sq.delete();
    mq.delete();
    desc_en = 4'b1000;
    build(4'b1000, 0);
    abort = 1'b0;
    rst_n = 1'b1;
    run_to_done("post_arst");

    for (int r = 0; r < 24; r++) begin
      start_run((r == 0) ? 4'hF : 4'($urandom_range(15)), 0);
      run_to_done("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
